// File: rtl/ssd_display_ctrl.sv
// ssd_display_ctrl: scans a signed 3-digit BCD reading "S U.T H" onto a 4-digit multiplexed seven-segment display.
// Optional macro SSD_PWM_DIM_EN: dims the anodes within each digit slot according to BRIGHT.
module ssd_display_ctrl #(
    parameter int REFRESH_DIV = 16,
    parameter int CNT_W       = 17
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [11:0] BCDIN,
    input  logic        SIGN,
    input  logic        LOAD,
    input  logic [3:0]  BRIGHT,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP
);
    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [11:0]      sh_bcd;
    logic             sh_sign;
    logic [3:0]       nib;
    logic [3:0]       an_n;
    logic [6:0]       seg_n;
    logic             lit;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0000110;
        endcase
    endfunction

`ifdef SSD_PWM_DIM_EN
    localparam logic [CNT_W:0] STEP = (CNT_W+1)'(REFRESH_DIV / 16);
    logic [CNT_W:0] lim;
    assign lim = ((CNT_W+1)'(BRIGHT) + (CNT_W+1)'(1)) * STEP;
    assign lit = {1'b0, cnt} < lim;
`else
    logic unused_bright;
    assign unused_bright = ^BRIGHT;
    assign lit = 1'b1;
`endif

    always_comb begin
        nib   = idx == 2'd0 ? sh_bcd[3:0] : idx == 2'd1 ? sh_bcd[7:4] : sh_bcd[11:8];
        seg_n = idx == 2'd3 ? (sh_sign ? 7'b0111111 : 7'b1111111) : decode(nib);
        an_n  = lit ? ~(4'b0001 << idx) : 4'b1111;
    end

    // Outputs are built from pre-LOAD shadow state, so a capture shows up one cycle later.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt     <= '0;
            idx     <= 2'd0;
            sh_bcd  <= 12'h000;
            sh_sign <= 1'b0;
            AN      <= 4'b1111;
            SEG     <= 7'b1111111;
            DP      <= 1'b1;
        end else begin
            cnt <= cnt == CNT_W'(REFRESH_DIV - 1) ? '0 : cnt + 1'b1;
            idx <= cnt == CNT_W'(REFRESH_DIV - 1) ? idx + 2'd1 : idx;
            if (LOAD) begin
                sh_bcd  <= BCDIN;
                sh_sign <= SIGN;
            end
            AN  <= an_n;
            SEG <= seg_n;
            DP  <= idx != 2'd2;
        end
    end
endmodule

// File: tb/tb_ssd_display_ctrl.sv
// tb_ssd_display_ctrl: random and directed stimulus, reference model feeds a queue, monitor compares every cycle.
module tb_ssd_display_ctrl;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [11:0] BCDIN = 12'h000;
    logic        SIGN = 1'b0;
    logic        LOAD = 1'b0;
    logic [3:0]  BRIGHT = 4'd15;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        DP;

    int total = 0;
    int bad = 0;

    ssd_display_ctrl #(.REFRESH_DIV(16), .CNT_W(17)) dut (
        .CLK(CLK), .RST(RST), .BCDIN(BCDIN), .SIGN(SIGN), .LOAD(LOAD),
        .BRIGHT(BRIGHT), .AN(AN), .SEG(SEG), .DP(DP)
    );

    always #5 CLK = ~CLK;

    logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    logic [11:0] exp_q [$];

    // Reference model: time since reset decides the slot; the visible shadow is the last loaded value.
    int          tick = 0;
    bit          started = 0;
    logic [11:0] m_bcd = 12'h000;
    logic        m_sign = 1'b0;
    always @(posedge CLK) begin
        int slot, pos, nv;
        logic [3:0] an;
        logic [6:0] seg;
        if (RST) started = 1;
        if (started) begin
            if (RST) begin
                exp_q.push_back({4'b1111, 7'b1111111, 1'b1});
                tick = 0;
                m_bcd = 12'h000;
                m_sign = 1'b0;
            end else begin
                slot = (tick / 16) % 4;
                pos = tick % 16;
                an = ~(4'b0001 << slot);
`ifdef SSD_PWM_DIM_EN
                if (pos > int'(BRIGHT)) an = 4'b1111;
`endif
                if (slot == 3) seg = m_sign ? 7'b0111111 : 7'b1111111;
                else begin
                    nv = (int'(m_bcd) >> (4 * slot)) % 16;
                    seg = nv > 9 ? 7'b0000110 : pat[nv];
                end
                exp_q.push_back({an, seg, slot != 2});
                if (LOAD) begin
                    m_bcd = BCDIN;
                    m_sign = SIGN;
                end
                tick++;
            end
        end
    end

    always @(negedge CLK) begin
        logic [11:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if ({AN, SEG, DP} !== e) begin
                bad++;
                $display("FAIL scan t=%0t got AN=%b SEG=%b DP=%b want AN=%b SEG=%b DP=%b",
                         $time, AN, SEG, DP, e[11:8], e[7:1], e[0]);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic load1(input logic [11:0] b, input logic s);
        BCDIN = b;
        SIGN = s;
        LOAD = 1'b1;
        cyc(1);
        LOAD = 1'b0;
    endtask

    initial begin
        cyc(3);
        RST = 1'b0;
        cyc(20);
        load1(12'h187, 1'b1);
        cyc(70);
        load1(12'hA05, 1'b0);
        cyc(70);
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        cyc(21);
        load1(12'h123, 1'b0);
        cyc(30);
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        cyc(20);
        BRIGHT = 4'd3;
        load1(12'h999, 1'b1);
        cyc(80);
        BRIGHT = 4'd0;
        cyc(70);
        BRIGHT = 4'd15;
        cyc(70);
        for (int i = 0; i < 1500; i++) begin
            BCDIN = 12'($urandom);
            SIGN = 1'($urandom);
            if (i % 200 < 30) LOAD = 1'b1;
            else LOAD = ($urandom % 8) == 0;
            if ($urandom % 40 == 0) BRIGHT = 4'($urandom);
            RST = ($urandom % 300) == 0;
            cyc(1);
        end
        LOAD = 1'b0;
        RST = 1'b0;
        cyc(3);
        total++;
        if (total < 1900) begin
            bad++;
            $display("FAIL count got=%0d want>=1900", total);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
